// File: rtl/bb_stream_pkg.sv
// Shared types and constants for the streaming register slices.
package bb_stream_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int CNT_W  = 2;
  localparam int DEF_DW = 8;

endpackage

// File: rtl/bb_skid_buffer_if.sv
// Producer/consumer handshake bundle around the skid buffer.
// The master side is the surrounding fabric and the slave side is the buffer.
interface bb_skid_buffer_if
  import bb_stream_pkg::*;
#(
  parameter int DW = DEF_DW
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/bb_data_slot.sv
// Enable-loaded payload register with async reset to a fixed value.
module bb_data_slot
  import bb_stream_pkg::*;
#(
  parameter int          DW      = DEF_DW,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       data_q <= RST_VAL;
    else if (en_i) data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/bb_skid_buffer.sv
// Two-entry valid/ready skid buffer: ready is a registered state decode, so the
// consumer's out_ready never reaches in_ready combinationally.
module bb_skid_buffer
  import bb_stream_pkg::*;
#(
  parameter int          DW      = DEF_DW,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  bb_skid_buffer_if.slave  bus
);

  skid_state_e   state_q, state_d;
  logic          in_fire, out_fire;
  logic          main_en, skid_en;
  logic [DW-1:0] main_d, main_q, skid_q;

  // flush gates both handshakes, so no fire can coincide with a flush
  assign bus.out_valid = (state_q != EMPTY) & ~bus.flush;
  assign bus.in_ready  = (state_q != FULL)  & ~bus.flush;
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (in_fire) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            skid_en = 1'b1;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: if (out_fire) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // main refills from skid when draining FULL, otherwise from the producer
  assign main_d = (state_q == FULL) ? skid_q : bus.in_data;

  bb_data_slot #(.DW(DW), .RST_VAL(RST_VAL)) u_main (
    .clk  (clk),
    .rst  (rst),
    .en_i (main_en),
    .d_i  (main_d),
    .q_o  (main_q)
  );

  bb_data_slot #(.DW(DW), .RST_VAL(RST_VAL)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .en_i (skid_en),
    .d_i  (bus.in_data),
    .q_o  (skid_q)
  );

  assign bus.out_data = main_q;

  always_comb begin
    unique case (state_q)
      BUSY:    bus.count = CNT_W'(1);
      FULL:    bus.count = CNT_W'(2);
      default: bus.count = CNT_W'(0);
    endcase
  end

endmodule

// File: tb/tb_bb_skid_buffer.sv
// Self-checking bench for bb_skid_buffer against a queue-based model.
module tb_bb_skid_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] q[$];
  logic acc;

  always #5 clk = ~clk;

  bb_skid_buffer_if #(.DW(8)) bus ();

  bb_skid_buffer #(.DW(8), .RST_VAL(8'h00)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle, check outputs against the model, then advance the model.
  task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    logic ev, er;
    int   sz;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    sz = q.size();
    ev = (sz != 0) && !fl;
    er = (sz != 2) && !fl;
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("in_ready",  32'(bus.in_ready),  32'(er));
    chk("count",     32'(bus.count),     32'(sz));
    if (ev) chk("out_data", 32'(bus.out_data), 32'(q[0]));
    bus.out_ready = ~ordy;
    #1;
    chk("in_ready_vs_out_ready", 32'(bus.in_ready), 32'(er));
    bus.out_ready = ordy;
    #1;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (ev && ordy) void'(q.pop_front());
      if (iv && er) q.push_back(id);
    end
    acc = iv && er && !fl;
    #1;
  endtask

  initial begin
    logic       iv, hold;
    logic [7:0] id;
    int         got, cyc;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    acc = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready",  32'(bus.in_ready),  1);
    chk("rst_count",     32'(bus.count),     0);
    chk("rst_out_data",  32'(bus.out_data),  0);
    @(posedge clk); #1;
    rst = 1'b0;

    // async reset while FULL
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    chk("full_count", 32'(bus.count), 2);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_in_ready",  32'(bus.in_ready),  1);
    chk("arst_count",     32'(bus.count),     0);
    chk("arst_out_data",  32'(bus.out_data),  0);
    #1;
    rst = 1'b0;
    q.delete();

    // full-rate streaming
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_drained", 32'(bus.count), 0);

    // backpressure into skid, then drain
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    chk("bp_out_data", 32'(bus.out_data), 32'h11);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // simultaneous fire in BUSY
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b1, 1'b0);
    chk("sim_out_data", 32'(bus.out_data), 32'h44);
    chk("sim_count",    32'(bus.count),    1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // flush while FULL, then refill
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    chk("flush_count", 32'(bus.count), 0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("post_flush_data", 32'(bus.out_data), 32'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // randomized traffic against the queue model
    hold = 1'b0; iv = 1'b0; id = '0; got = 0; cyc = 0;
    while (got < 10000 && cyc < 40000) begin
      if (!hold) begin
        iv = ($urandom_range(0, 3) != 0);
        id = 8'($urandom);
      end
      step(iv, id, ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
      if (acc) got++;
      hold = iv && !acc;
      cyc++;
    end
    if (got < 10000) chk("random_budget", 32'(got), 32'd10000);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("final_count", 32'(bus.count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bb_skid_buffer.md
Name: bb_skid_buffer

Overview:
- Two-entry valid/ready register slice (skid buffer) in front of the enable-loaded data registers of the datapath.
- Breaks the combinational ready path between producer and consumer while sustaining full throughput.
- Converts a streaming handshake into clean per-slot load enables for its storage registers.
- Adds a synchronous flush and an occupancy count for the auto-connect fabric.

Parameters:
- DW, 8, payload width in bits.
- RST_VAL, 0, reset value of both storage slots and of out_data.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- flush  in  1  synchronous discard of all held beats.
- in_valid  in  1  producer has a beat.
- in_ready  out  1  buffer can accept; a registered state decode, with no combinational path from out_ready.
- in_data  in  DW  producer payload.
- out_valid  out  1  buffer presents a beat.
- out_ready  in  1  consumer accepts.
- out_data  out  DW  payload, driven directly from the main slot register.
- count  out  2  beats held: 0, 1 or 2.

Behaviour:
- Handshake rules:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - The producer must hold in_valid and in_data stable until in_fire.
  - out_valid, once high, stays high with out_data stable until out_fire or flush.
- State machine: EMPTY, BUSY (main slot full), FULL (main and skid slots full).
- Output decodes:
  - out_valid = (state != EMPTY) & ~flush.
  - in_ready = (state != FULL) & ~flush.
  - count = 0 / 1 / 2 for EMPTY / BUSY / FULL.
- Reset (rst=1, any time including mid-transfer):
  - state = EMPTY.
  - main and skid slots = RST_VAL.
  - out_valid = 0, in_ready = 1, count = 0, out_data = RST_VAL.
  - Takes effect without a clock edge.
- Transitions (no flush):
  - EMPTY, in_fire: main <= in_data, go to BUSY.
  - BUSY, in_fire & out_fire: main <= in_data, stay in BUSY. Full-rate streaming.
  - BUSY, in_fire only: skid <= in_data, go to FULL.
  - BUSY, out_fire only: go to EMPTY.
  - FULL (in_fire impossible), out_fire: main <= skid, go to BUSY.
  - All other cases: hold.
- Flush (sync, flush=1 at an edge):
  - Next state = EMPTY regardless of other inputs.
  - No in_fire or out_fire occurs in that cycle, because both handshakes are gated.
  - Slot contents are not cleared. out_data keeps its stale value but is qualified by out_valid=0.
  - rst overrides flush.
- Latency and ordering:
  - 1 cycle from in_fire to out_valid when the buffer was EMPTY.
  - Strict FIFO order; no beat is dropped or duplicated.
  - Sustained throughput is 1 beat/clk while out_ready=1.
- Backpressure:
  - When out_ready drops in BUSY, one more beat is absorbed into skid.
  - in_ready then deasserts the following cycle.
- Slot load enables are one-hot per edge:
  - main_en = (EMPTY & in_fire) | (BUSY & in_fire & out_fire) | (FULL & out_fire).
  - skid_en = BUSY & in_fire & ~out_fire.
- Unused data bits have no X-propagation requirement; all registers are reset.

Decomposition:
- Shared package bb_stream_pkg:
  - skid_state_e enum (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2).
  - Localparam for count width (2).
  - Default DW.
- One natural sub-module: bb_data_slot.
  - DW-wide register with async active-high reset to RST_VAL and a load enable.
  - Instantiated twice, for main and skid.
- FSM and enable decode stay in the top module.

Test Plan:
1. rst pulse mid-cycle while FULL holding 0xA1/0xA2 -> immediately out_valid=0, in_ready=1, count=0, out_data=0x00; no edge required.
2. Stream 0x01..0x10 with out_ready=1 constantly -> outputs appear 1 cycle after acceptance, 16 beats in 16 consecutive cycles, in_ready never drops, count stays 1.
3. Push 0x11, then 0x22 with out_ready=0 -> count=2, in_ready=0, out_data=0x11. Raise out_ready -> 0x11 then 0x22 delivered on consecutive cycles, count returns to 0.
4. Simultaneous in_fire/out_fire in BUSY holding 0x33, with input 0x44 -> next cycle out_data=0x44, count=1, skid untouched.
5. FULL (0x55, 0x66), assert flush with in_valid=1 and out_ready=1 -> no handshake that cycle, next cycle count=0, out_valid=0, in_ready=1. Then push 0x77 -> next output is 0x77.
6. Random valid/ready over 10k beats with a scoreboard -> order preserved, no loss or duplication, in_ready never depends combinationally on out_ready (checked by assertion).
